// File: rtl/kv_cuckoo_insert_if.sv
// Insertion request channel for kv_cuckoo_insert.
// master: ins_valid/ins_key/ins_value_addr out, ins_ready in; slave: reverse.
interface kv_cuckoo_insert_if #(
   parameter int KEY_WIDTH   = 32,
   parameter int VALUE_WIDTH = 32
);
   logic                   ins_valid;
   logic                   ins_ready;
   logic [KEY_WIDTH-1:0]   ins_key;
   logic [VALUE_WIDTH-1:0] ins_value_addr;

   modport master (
      output ins_valid, ins_key, ins_value_addr,
      input  ins_ready
   );

   modport slave (
      input  ins_valid, ins_key, ins_value_addr,
      output ins_ready
   );
endinterface

// File: rtl/kv_cuckoo_insert.sv
// Cuckoo-hash insertion engine over two synchronous-read tables.
// Ports: clock, reset_n, clr_req, ins (request slave), done/fail/update status, fail entry.
module kv_cuckoo_insert #(
   parameter int KEY_WIDTH     = 32,
   parameter int VALUE_WIDTH   = 32,
   parameter int RAM_ADDR_BITS = 9,
   parameter int MAX_KICKS     = 16
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     clr_req,
   kv_cuckoo_insert_if.slave        ins,
   output logic                     ins_done,
   output logic                     ins_fail,
   output logic                     ins_update,
   output logic                     ins_table,
   output logic [RAM_ADDR_BITS-1:0] ins_index,
   output logic [7:0]               ins_kicks,
   output logic [KEY_WIDTH-1:0]     fail_key,
   output logic [VALUE_WIDTH-1:0]   fail_value_addr
);
   localparam int A     = RAM_ADDR_BITS;
   localparam int DEPTH = 1 << A;

   typedef struct packed {
      logic                   vld;
      logic [KEY_WIDTH-1:0]   key;
      logic [VALUE_WIDTH-1:0] val;
   } ent_t;

   typedef enum logic [2:0] {
      S_CLEAR, S_IDLE, S_READ, S_CHECK, S_DONE
   } state_e;

   typedef enum logic [2:0] {
      O_KICK, O_UPD1, O_UPD2, O_NEW1, O_NEW2, O_FAIL
   } out_e;

   ent_t r_t1 [DEPTH];
   ent_t r_t2 [DEPTH];
   ent_t r_rd1, r_rd2;

   state_e                 r_state;
   logic [A-1:0]           r_cnt;
   logic [KEY_WIDTH-1:0]   r_cur_key;
   logic [VALUE_WIDTH-1:0] r_cur_val;
   logic                   r_side;
   logic [7:0]             r_kicks;
   logic                   r_ready, r_done, r_fail, r_upd, r_tbl;
   logic [A-1:0]           r_idx;
   logic [7:0]             r_okicks;
   logic [KEY_WIDTH-1:0]   r_fkey;
   logic [VALUE_WIDTH-1:0] r_fval;

   logic [A-1:0] w_h1, w_h2, w_a1, w_a2;
   logic         w_m1, w_m2, w_we1, w_we2, w_rd;
   ent_t         w_wd;
   out_e         w_out;

   // Only the low 2A key bits feed the hashes
   assign w_h1 = r_cur_key[A-1:0];
   assign w_h2 = r_cur_key[2*A-1:A] ^ ~r_cur_key[A-1:0];
   assign w_m1 = r_rd1.vld && (r_rd1.key == r_cur_key);
   assign w_m2 = r_rd2.vld && (r_rd2.key == r_cur_key);
   assign w_rd = (r_state == S_READ);

   always_comb begin
      w_out = O_KICK;
      w_we1 = 1'b0;
      w_we2 = 1'b0;
      w_a1  = w_h1;
      w_a2  = w_h2;
      w_wd  = '{vld: 1'b1, key: r_cur_key, val: r_cur_val};
      if (r_state == S_CLEAR) begin
         w_we1 = 1'b1;
         w_we2 = 1'b1;
         w_a1  = r_cnt;
         w_a2  = r_cnt;
         w_wd  = '0;
      end else if (r_state == S_CHECK) begin
         if (w_m1)                          w_out = O_UPD1;
         else if (w_m2)                     w_out = O_UPD2;
         else if (!r_rd1.vld)               w_out = O_NEW1;
         else if (!r_rd2.vld)               w_out = O_NEW2;
         else if (r_kicks == 8'(MAX_KICKS)) w_out = O_FAIL;
         case (w_out)
            O_UPD1, O_NEW1: w_we1 = 1'b1;
            O_UPD2, O_NEW2: w_we2 = 1'b1;
            O_KICK: begin
               w_we1 = !r_side;
               w_we2 = r_side;
            end
            default: ;
         endcase
      end
   end

   // Table storage: no reset, cleared by the sweep
   always_ff @(posedge clock) begin
      if (w_we1) r_t1[w_a1] <= w_wd;
      if (w_we2) r_t2[w_a2] <= w_wd;
      if (w_rd) begin
         r_rd1 <= r_t1[w_h1];
         r_rd2 <= r_t2[w_h2];
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= S_CLEAR;
         r_cnt     <= '0;
         r_cur_key <= '0;
         r_cur_val <= '0;
         r_side    <= 1'b0;
         r_kicks   <= '0;
         r_ready   <= 1'b0;
         r_done    <= 1'b0;
         r_fail    <= 1'b0;
         r_upd     <= 1'b0;
         r_tbl     <= 1'b0;
         r_idx     <= '0;
         r_okicks  <= '0;
         r_fkey    <= '0;
         r_fval    <= '0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            S_CLEAR: begin
               r_cnt <= r_cnt + 1'b1;
               if (&r_cnt) begin
                  r_state <= S_IDLE;
                  r_ready <= 1'b1;
               end
            end
            S_IDLE: begin
               if (clr_req) begin
                  r_state <= S_CLEAR;
                  r_cnt   <= '0;
                  r_ready <= 1'b0;
               end else if (ins.ins_valid) begin
                  r_state   <= S_READ;
                  r_ready   <= 1'b0;
                  r_cur_key <= ins.ins_key;
                  r_cur_val <= ins.ins_value_addr;
                  r_side    <= 1'b0;
                  r_kicks   <= '0;
               end
            end
            S_READ: r_state <= S_CHECK;
            S_CHECK: begin
               if (w_out == O_KICK) begin
                  // Evicted entry becomes the one to place next
                  r_cur_key <= r_side ? r_rd2.key : r_rd1.key;
                  r_cur_val <= r_side ? r_rd2.val : r_rd1.val;
                  r_side    <= !r_side;
                  r_kicks   <= r_kicks + 8'd1;
                  r_state   <= S_READ;
               end else begin
                  r_state  <= S_DONE;
                  r_done   <= 1'b1;
                  r_okicks <= r_kicks;
                  r_fail   <= (w_out == O_FAIL);
                  r_upd    <= (w_out == O_UPD1) || (w_out == O_UPD2);
                  if (w_out == O_FAIL) begin
                     r_fkey <= r_cur_key;
                     r_fval <= r_cur_val;
                  end else begin
                     r_tbl <= w_we2;
                     r_idx <= w_we2 ? w_h2 : w_h1;
                  end
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_ready <= 1'b1;
            end
            default: r_state <= S_CLEAR;
         endcase
      end
   end

   assign ins.ins_ready     = r_ready;
   assign ins_done          = r_done;
   assign ins_fail          = r_fail;
   assign ins_update        = r_upd;
   assign ins_table         = r_tbl;
   assign ins_index         = r_idx;
   assign ins_kicks         = r_okicks;
   assign fail_key          = r_fkey;
   assign fail_value_addr   = r_fval;
endmodule

// File: tb/tb_kv_cuckoo_insert.sv
// Directed bench for kv_cuckoo_insert: two instances, MAX_KICKS=16 (a) and 0 (b).
// Expected values are hand-derived hash placements and latencies.
module tb_kv_cuckoo_insert;
   localparam int KW = 32;
   localparam int VW = 32;
   localparam int A  = 4;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;
   logic clr_a   = 1'b0;
   logic clr_b   = 1'b0;
   logic sel     = 1'b0;
   int   n_vec   = 0;
   int   n_mis   = 0;

   always #5 clock = ~clock;

   kv_cuckoo_insert_if #(.KEY_WIDTH(KW), .VALUE_WIDTH(VW)) bus_a ();
   kv_cuckoo_insert_if #(.KEY_WIDTH(KW), .VALUE_WIDTH(VW)) bus_b ();

   logic          done_a, fail_a, upd_a, tbl_a;
   logic [A-1:0]  idx_a;
   logic [7:0]    kicks_a;
   logic [KW-1:0] fkey_a;
   logic [VW-1:0] fval_a;
   logic          done_b, fail_b, upd_b, tbl_b;
   logic [A-1:0]  idx_b;
   logic [7:0]    kicks_b;
   logic [KW-1:0] fkey_b;
   logic [VW-1:0] fval_b;

   kv_cuckoo_insert #(
      .KEY_WIDTH(KW), .VALUE_WIDTH(VW), .RAM_ADDR_BITS(A), .MAX_KICKS(16)
   ) u_a (
      .clock(clock), .reset_n(reset_n), .clr_req(clr_a), .ins(bus_a.slave),
      .ins_done(done_a), .ins_fail(fail_a), .ins_update(upd_a),
      .ins_table(tbl_a), .ins_index(idx_a), .ins_kicks(kicks_a),
      .fail_key(fkey_a), .fail_value_addr(fval_a)
   );

   kv_cuckoo_insert #(
      .KEY_WIDTH(KW), .VALUE_WIDTH(VW), .RAM_ADDR_BITS(A), .MAX_KICKS(0)
   ) u_b (
      .clock(clock), .reset_n(reset_n), .clr_req(clr_b), .ins(bus_b.slave),
      .ins_done(done_b), .ins_fail(fail_b), .ins_update(upd_b),
      .ins_table(tbl_b), .ins_index(idx_b), .ins_kicks(kicks_b),
      .fail_key(fkey_b), .fail_value_addr(fval_b)
   );

   logic          m_ready, m_done, m_fail, m_upd, m_tbl;
   logic [A-1:0]  m_idx;
   logic [7:0]    m_kicks;
   logic [KW-1:0] m_fkey;
   logic [VW-1:0] m_fval;

   assign m_ready = sel ? bus_b.ins_ready : bus_a.ins_ready;
   assign m_done  = sel ? done_b  : done_a;
   assign m_fail  = sel ? fail_b  : fail_a;
   assign m_upd   = sel ? upd_b   : upd_a;
   assign m_tbl   = sel ? tbl_b   : tbl_a;
   assign m_idx   = sel ? idx_b   : idx_a;
   assign m_kicks = sel ? kicks_b : kicks_a;
   assign m_fkey  = sel ? fkey_b  : fkey_a;
   assign m_fval  = sel ? fval_b  : fval_a;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input logic v, input logic [KW-1:0] k,
                          input logic [VW-1:0] d);
      if (sel) begin
         bus_b.ins_valid      = v;
         bus_b.ins_key        = k;
         bus_b.ins_value_addr = d;
      end else begin
         bus_a.ins_valid      = v;
         bus_a.ins_key        = k;
         bus_a.ins_value_addr = d;
      end
   endtask

   task automatic wait_ready(output int n);
      n = 0;
      while (!m_ready && n < 100) begin
         @(posedge clock); #1;
         n++;
      end
   endtask

   // Issue one insert; lat counts cycles from acceptance to ins_done
   task automatic ins(input logic [KW-1:0] k, input logic [VW-1:0] d,
                      output int lat);
      int n;
      wait_ready(n);
      set_req(1'b1, k, d);
      @(posedge clock); #1;
      set_req(1'b0, '0, '0);
      lat = 1;
      while (!m_done && lat < 200) begin
         @(posedge clock); #1;
         lat++;
      end
   endtask

   task automatic st(input string tag, input int lat, input int e_lat,
                     input logic e_fail, input logic e_upd,
                     input logic e_tbl, input logic [A-1:0] e_idx,
                     input logic [7:0] e_kicks);
      chk({tag, "_lat"},   64'(lat),     64'(e_lat));
      chk({tag, "_fail"},  64'(m_fail),  64'(e_fail));
      chk({tag, "_upd"},   64'(m_upd),   64'(e_upd));
      chk({tag, "_tbl"},   64'(m_tbl),   64'(e_tbl));
      chk({tag, "_idx"},   64'(m_idx),   64'(e_idx));
      chk({tag, "_kicks"}, 64'(m_kicks), 64'(e_kicks));
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_ready"}, 64'(m_ready), 64'd0);
      chk({tag, "_done"},  64'(m_done),  64'd0);
      chk({tag, "_fail"},  64'(m_fail),  64'd0);
      chk({tag, "_upd"},   64'(m_upd),   64'd0);
      chk({tag, "_tbl"},   64'(m_tbl),   64'd0);
      chk({tag, "_idx"},   64'(m_idx),   64'd0);
      chk({tag, "_kicks"}, 64'(m_kicks), 64'd0);
      chk({tag, "_fkey"},  64'(m_fkey),  64'd0);
      chk({tag, "_fval"},  64'(m_fval),  64'd0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int n;
      bus_a.ins_valid = 1'b0;
      bus_a.ins_key = '0;
      bus_a.ins_value_addr = '0;
      bus_b.ins_valid = 1'b0;
      bus_b.ins_key = '0;
      bus_b.ins_value_addr = '0;

      // Reset state and sweep length
      repeat (3) @(posedge clock);
      #1;
      sel = 1'b0;
      chk_reset_vals("rst_a");
      reset_n = 1'b1;
      n = 0;
      while (!bus_a.ins_ready && n < 100) begin
         @(posedge clock); #1;
         n++;
      end
      chk("rst_ready_cycles", 64'(n), 64'd16);
      chk("rst_ready_b", 64'(bus_b.ins_ready), 64'd1);

      // Instance a: direct placements, one kick, update after kick
      ins('h03, 'hAA, lat);
      st("a_03", lat, 3, 0, 0, 0, 4'h3, 0);
      @(posedge clock); #1;
      chk("a_03_pulse", 64'(m_done), 64'd0);
      chk("a_03_rdy", 64'(m_ready), 64'd1);
      ins('h13, 'hBB, lat);
      st("a_13", lat, 3, 0, 0, 1, 4'hD, 0);
      ins('h23, 'hCC, lat);
      st("a_23", lat, 3, 0, 0, 1, 4'hE, 0);
      ins('h113, 'hDD, lat);
      st("a_113", lat, 5, 0, 0, 1, 4'hC, 1);
      ins('h03, 'hEE, lat);
      st("a_03u", lat, 3, 0, 1, 1, 4'hC, 0);

      // Instance b (MAX_KICKS=0): update, fail, tables unchanged, clr_req
      sel = 1'b1;
      ins('h03, 'hAA, lat);
      st("b_03", lat, 3, 0, 0, 0, 4'h3, 0);
      ins('h03, 'hEE, lat);
      st("b_03u", lat, 3, 0, 1, 0, 4'h3, 0);
      ins('h13, 'hBB, lat);
      st("b_13", lat, 3, 0, 0, 1, 4'hD, 0);
      ins('h113, 'hDD, lat);
      st("b_113f", lat, 3, 1, 0, 1, 4'hD, 0);
      chk("b_fkey", 64'(m_fkey), 64'h113);
      chk("b_fval", 64'(m_fval), 64'hDD);
      ins('h03, 'hAA, lat);
      st("b_03u2", lat, 3, 0, 1, 0, 4'h3, 0);
      wait_ready(n);
      clr_b = 1'b1;
      @(posedge clock); #1;
      clr_b = 1'b0;
      n = 1;
      while (!bus_b.ins_ready && n < 100) begin
         @(posedge clock); #1;
         n++;
      end
      chk("b_clr_cycles", 64'(n), 64'd17);
      ins('h03, 'hAA, lat);
      st("b_03c", lat, 3, 0, 0, 0, 4'h3, 0);

      // Instance a: three keys sharing both buckets exhaust 16 kicks
      sel = 1'b0;
      ins('h213, 'h11, lat);
      st("a_213f", lat, 35, 1, 0, 1, 4'hC, 8'd16);
      chk("a_fkey", 64'(m_fkey), 64'h113);
      chk("a_fval", 64'(m_fval), 64'hDD);

      // Reset inside a kick loop
      wait_ready(n);
      set_req(1'b1, 'h113, 'hDD);
      @(posedge clock); #1;
      set_req(1'b0, '0, '0);
      repeat (6) @(posedge clock);
      #1;
      reset_n = 1'b0;
      #1;
      chk_reset_vals("mid_rst");
      @(posedge clock); #1;
      chk("mid_rst_nopulse", 64'(m_done), 64'd0);
      reset_n = 1'b1;
      n = 0;
      while (!bus_a.ins_ready && n < 100) begin
         @(posedge clock); #1;
         n++;
      end
      chk("mid_rst_ready", 64'(n), 64'd16);
      ins('h13, 'hBB, lat);
      st("r_13", lat, 3, 0, 0, 0, 4'h3, 0);
      ins('h03, 'hAA, lat);
      st("r_03", lat, 3, 0, 0, 1, 4'hC, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end
endmodule

// File: doc/kv_cuckoo_insert.md
# kv_cuckoo_insert

Write-side companion to the key-value lookup BRAMs: accepts (key, value_addr) insertion requests over a valid/ready handshake and places them into two hash tables using cuckoo displacement. Lookups resolve a key through these same tables. On reset or request the block sweeps both tables invalid. Each completed insertion reports a status pulse with the final placement, the kick count, and any entry dropped on failure.

## Interface
- KEY_WIDTH, 32, key width; must be >= 2*RAM_ADDR_BITS
- VALUE_WIDTH, 32, width of stored value address
- RAM_ADDR_BITS, 9, index width per table; depth 2^RAM_ADDR_BITS each
- MAX_KICKS, 16, maximum evictions per insertion, range 0..255
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- clr_req  in  1  sampled in IDLE: start a full table sweep
- ins_valid  in  1  insertion request valid
- ins_ready  out  1  high only in IDLE
- ins_key  in  KEY_WIDTH  key to insert
- ins_value_addr  in  VALUE_WIDTH  value address to store
- ins_done  out  1  one-cycle completion pulse
- ins_fail  out  1  qualifies ins_done: MAX_KICKS exhausted
- ins_update  out  1  qualifies ins_done: key already present, value overwritten
- ins_table  out  1  table of final write (0 = T1, 1 = T2)
- ins_index  out  RAM_ADDR_BITS  index of final write
- ins_kicks  out  8  evictions performed
- fail_key / fail_value_addr  out  KEY_WIDTH / VALUE_WIDTH  entry left homeless on fail

## Operation
- Each table entry is {valid, key, value_addr}, held in synchronous-read RAM.
- Let A = RAM_ADDR_BITS. Hashes: h1 = key[A-1:0]; h2 = key[2A-1:A] ^ ~key[A-1:0]. Key bits at 2A and above do not affect either hash.
- FSM states: CLEAR, IDLE, READ, CHECK, DONE.
- CLEAR: counter 0..2^A-1 writes valid=0 to both tables, one index per cycle, then goes to IDLE. Entered after reset, and from IDLE when clr_req=1. clr_req has priority over ins_valid.
- IDLE: on ins_valid && ins_ready, latch cur = {key, value}, side=0, kicks=0, then go to READ.
- READ: issue reads T1[h1(cur)] and T2[h2(cur)], then go to CHECK.
- CHECK, checked in priority order:
  - either slot is valid with key == cur.key: overwrite that slot, update=1, go to DONE. T1 wins if both match.
  - T1 slot invalid: write T1, go to DONE.
  - T2 slot invalid: write T2, go to DONE.
  - kicks == MAX_KICKS: fail=1, no write, go to DONE.
  - otherwise: write cur into T[side], and the old T[side] entry becomes cur. Then kicks++, side toggles, go to READ.
- DONE: ins_done=1 for one cycle, with the status outputs valid. Next state is IDLE.
- Status outputs hold their values until the next DONE. ins_table/ins_index give the location of the last successful write.
- On fail, the homeless entry may be displaced data rather than the original key. It is reported on fail_key/fail_value_addr.
- Comparisons use the full KEY_WIDTH.

## Timing
- Reset values: ins_ready=0, ins_done=0, ins_fail=0, ins_update=0, ins_table=0, ins_index=0, ins_kicks=0, fail_key=0, fail_value_addr=0. The FSM goes to CLEAR.
- After reset_n deasserts, ins_ready rises after exactly 2^A cycles.
- Insert accepted at cycle T with k kicks: ins_done at T+3+2k, ins_ready again at T+4+2k.
- Requests presented while ins_ready=0 are ignored and not queued. The source holds ins_valid.
- clr_req costs 2^A cycles plus 1, during which ins_ready=0.
- Reset asserted mid-operation: outputs return to reset values immediately, with no partial-completion pulse. The table sweep then follows.
- Read-during-write to the same address does not occur, because a write only happens in CHECK and the next read is issued one cycle later.

## Test plan
Parameters for all scenarios: RAM_ADDR_BITS=4, MAX_KICKS=16 unless stated. All keys and values in hex.
- Reset then insert key 03, value AA at cycle T -> ins_ready rises 16 cycles after reset release. ins_done at T+3 with table 0, index 3, kicks 0, fail 0, update 0.
- Insert 03/AA, then 13/BB -> second insert reports table 1, index D. Then insert 23/CC -> table 1, index E.
- With 03 and 13 resident, insert 113/DD -> T1[3] becomes 113 and 03 moves to T2[C]. Status: table 1, index C, kicks 1, ins_done at T+5.
- Insert 03/AA then 03/EE -> second insert reports update=1, table 0, index 3, kicks 0, ins_done at T+3.
- MAX_KICKS=0, with 03 and 13 resident, insert 113/DD -> fail=1, fail_key=113, fail_value_addr=DD. A following insert of 03/AA returns update=1 at T1[3], showing the tables were unchanged.
- Pull reset_n low during the kick loop of the third scenario -> all outputs go to reset values. After the 16-cycle sweep, insert 13/BB -> table 0, index 3, kicks 0, showing the tables were cleared.
